// File: rtl/sync_shot_sequencer.sv
// sync_shot_sequencer: start -> opto mark -> programmed delay -> fire -> debounced wire -> trigger -> detector handshake.
module sync_shot_sequencer #(
  parameter int CNT_W         = 24,
  parameter int FIRE_WIDTH    = 50,
  parameter int TRIG_WIDTH    = 10,
  parameter int DEBOUNCE      = 16,
  parameter int OPTO_TIMEOUT  = 2_500_000,
  parameter int WIRE_TIMEOUT  = 5_000,
  parameter int READY_TIMEOUT = 500_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] fire_delay,
  input  logic             fg_opto,
  input  logic             wire_sensor,
  input  logic             detector_ready,
  output logic             detonator_fire,
  output logic             output_trigger,
  output logic             busy,
  output logic             done,
  output logic [1:0]       err_code
);
  localparam int DB_W = $clog2(DEBOUNCE + 1);
  typedef enum logic [3:0] {IDLE, WAIT_OPTO, DELAY, FIRE, WAIT_WIRE, TRIGGER, WAIT_READY, DONE, ERROR} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, dly_q, dly_d;
  logic [DB_W-1:0] deb_q, deb_d;
  // bit 0/1: synchronizer stages, bit 2: delay flop for edge detection
  logic [2:0] start_s_q, opto_s_q, wire_s_q, rdy_s_q;
  logic seen_fall_q, seen_fall_d, fire_q, fire_d, trig_q, trig_d;
  logic busy_q, busy_d, done_q, done_d;
  logic [1:0] err_q, err_d;
  logic start_rise, opto_rise, rdy_rise, rdy_fall, cnt_zero;
  assign start_rise = start_s_q[1] & ~start_s_q[2];
  assign opto_rise = opto_s_q[1] & ~opto_s_q[2];
  assign rdy_rise = rdy_s_q[1] & ~rdy_s_q[2];
  assign rdy_fall = ~rdy_s_q[1] & rdy_s_q[2];
  assign cnt_zero = cnt_q == '0;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_zero ? cnt_q : cnt_q - CNT_W'(1);
    dly_d = dly_q;
    deb_d = '0;
    seen_fall_d = seen_fall_q;
    fire_d = 1'b0;
    trig_d = 1'b0;
    err_d = err_q;
    case (state_q)
      IDLE, DONE, ERROR:
        if (start_rise) begin
          state_d = WAIT_OPTO;
          dly_d = fire_delay;
          err_d = 2'd0;
          cnt_d = CNT_W'(OPTO_TIMEOUT - 1);
        end
      WAIT_OPTO:
        if (opto_rise) begin
          state_d = DELAY;
          cnt_d = dly_q;
        end else if (cnt_zero) begin
          state_d = ERROR;
          err_d = 2'd1;
        end
      DELAY:
        if (cnt_zero) begin
          state_d = FIRE;
          fire_d = 1'b1;
          cnt_d = CNT_W'(FIRE_WIDTH - 1);
        end
      FIRE:
        if (cnt_zero) begin
          state_d = WAIT_WIRE;
          cnt_d = CNT_W'(WIRE_TIMEOUT - 1);
        end else fire_d = 1'b1;
      WAIT_WIRE: begin
        deb_d = wire_s_q[1] ? deb_q + DB_W'(1) : '0;
        if (deb_d == DB_W'(DEBOUNCE)) begin
          state_d = TRIGGER;
          trig_d = 1'b1;
          cnt_d = CNT_W'(TRIG_WIDTH - 1);
        end else if (cnt_zero) begin
          state_d = ERROR;
          err_d = 2'd2;
        end
      end
      TRIGGER:
        if (cnt_zero) begin
          state_d = WAIT_READY;
          seen_fall_d = 1'b0;
          cnt_d = CNT_W'(READY_TIMEOUT - 1);
        end else trig_d = 1'b1;
      WAIT_READY:
        if (seen_fall_q && rdy_rise) state_d = DONE;
        else if (cnt_zero) begin
          state_d = ERROR;
          err_d = 2'd3;
        end else if (rdy_fall) seen_fall_d = 1'b1;
      default: state_d = IDLE;
    endcase
    busy_d = !(state_d inside {IDLE, DONE, ERROR});
    done_d = state_d == DONE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      dly_q <= '0;
      deb_q <= '0;
      start_s_q <= '0;
      opto_s_q <= '0;
      wire_s_q <= '0;
      rdy_s_q <= '0;
      seen_fall_q <= 1'b0;
      fire_q <= 1'b0;
      trig_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      dly_q <= dly_d;
      deb_q <= deb_d;
      start_s_q <= {start_s_q[1:0], start};
      opto_s_q <= {opto_s_q[1:0], fg_opto};
      wire_s_q <= {wire_s_q[1:0], wire_sensor};
      rdy_s_q <= {rdy_s_q[1:0], detector_ready};
      seen_fall_q <= seen_fall_d;
      fire_q <= fire_d;
      trig_q <= trig_d;
      busy_q <= busy_d;
      done_q <= done_d;
      err_q <= err_d;
    end
  end
  assign detonator_fire = fire_q;
  assign output_trigger = trig_q;
  assign busy = busy_q;
  assign done = done_q;
  assign err_code = err_q;
endmodule

// File: tb/tb_sync_shot_sequencer.sv
// tb_sync_shot_sequencer: randomized shots checked cycle by cycle against a timeline model built from the shot rules.
module tb_sync_shot_sequencer;
  localparam int CW = 24, FW = 50, TW = 10, DB = 16, OT = 300, WT = 200, RT = 250, N = 2048;
  logic clk = 0, reset = 1, start = 0, fg_opto = 0, wire_sensor = 0, detector_ready = 1;
  logic [CW-1:0] fire_delay = '0;
  logic detonator_fire, output_trigger, busy, done;
  logic [1:0] err_code;
  int n_vec = 0, n_bad = 0, sn = 0;
  logic st[N], op[N], wi[N], rd[N], rs[N];
  logic p_done = 0;
  logic [1:0] p_err = 0;
  always #10 clk = ~clk;
  sync_shot_sequencer #(
    .CNT_W(CW), .FIRE_WIDTH(FW), .TRIG_WIDTH(TW), .DEBOUNCE(DB),
    .OPTO_TIMEOUT(OT), .WIRE_TIMEOUT(WT), .READY_TIMEOUT(RT)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .fire_delay(fire_delay), .fg_opto(fg_opto),
    .wire_sensor(wire_sensor), .detector_ready(detector_ready), .detonator_fire(detonator_fire),
    .output_trigger(output_trigger), .busy(busy), .done(done), .err_code(err_code)
  );
  task automatic chk(input string tag, input logic [5:0] got, input logic [5:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b (busy,done,fire,trig,err)", tag, got, exp);
    end
  endtask
  // Edge numbering: inputs driven at negedge r are seen by posedge r+1; outputs sampled at negedge r reflect posedge r.
  task automatic run_shot(input int kind, input int d);
    int w = 5, ko, f = 0, x, t = -1, y, kf = -1, kr = -1, tend, len, h = -1, pos, lim, hi;
    logic od = 0;
    logic [1:0] code = 0;
    logic fired = 0;
    logic [5:0] exp;
    for (int i = 0; i < N; i++) begin
      st[i] = 0; op[i] = 0; wi[i] = 0; rd[i] = 1; rs[i] = 0;
    end
    fire_delay = CW'(d);
    st[2] = 1; st[3] = 1;
    if (kind == 1) begin
      tend = w + OT; code = 1;
      if ($urandom_range(1, 0) == 1) for (int i = 0; i < 4; i++) op[w + OT - 2 + i] = 1;
    end else begin
      ko = ($urandom_range(3, 0) == 0) ? w + OT - 3 : w - 3 + $urandom_range(OT, 2);
      for (int i = 0; i < 4; i++) op[ko + i] = 1;
      f = ko + d + 4; fired = 1; x = f + FW;
      pos = ko + 1 + $urandom_range(d, 0);
      st[pos] = 1; st[pos + 1] = 1;
      for (int i = 5; i < 8; i++) op[f + i] = 1;
      if (kind == 4) begin
        rs[f + 19] = 1;
        if ($urandom_range(1, 0) == 1) rs[f + 20] = 1;
        tend = f + 20;
      end else begin
        if (kind == 2) h = ($urandom_range(1, 0) == 1) ? x + WT - DB - 1 : -1;
        else h = ($urandom_range(3, 0) == 0) ? x + WT - DB - 2 : x + $urandom_range(100, 0);
        lim = (h >= 0) ? h - 1 : x + WT + 20;
        pos = x - 40;
        forever begin
          len = $urandom_range(15, 1);
          if (pos + len >= lim) break;
          for (int i = pos; i < pos + len; i++) wi[i] = 1;
          pos += len + $urandom_range(10, 1);
        end
        if (h >= 0) for (int i = h; i < h + DB + 40; i++) wi[i] = 1;
        for (int c = x + DB; c <= x + WT && t < 0; c++) begin
          hi = 0;
          for (int i = c - DB - 2; i <= c - 3; i++) hi += int'(wi[i]);
          if (hi == DB) t = c;
        end
        if (t < 0) begin
          tend = x + WT; code = 2;
        end else begin
          y = t + TW;
          if (!(kind == 3 && $urandom_range(1, 0) == 1)) begin
            kf = y - 2 + $urandom_range(60, 0);
            kr = (kind == 3) ? y + RT - 2 : (($urandom_range(3, 0) == 0) ? y + RT - 3 : kf + $urandom_range(80, 1));
            for (int i = kf; i < kr; i++) rd[i] = 0;
          end
          if (kf >= 0 && kf + 3 >= y + 1 && kf + 3 <= y + RT - 1 && kr > kf && kr + 3 <= y + RT) begin
            tend = kr + 3; od = 1;
          end else begin
            tend = y + RT; code = 3;
          end
        end
      end
    end
    for (int r = 0; r < tend + 110; r++) begin
      @(negedge clk);
      exp = {r >= w && r < tend,
             (r < w) ? p_done : (r >= tend && od),
             fired && r >= f && r < f + FW && r < tend,
             t >= 0 && r >= t && r < t + TW && r < tend,
             (r < w) ? p_err : ((r >= tend) ? code : 2'd0)};
      chk($sformatf("shot%0d kind%0d r%0d", sn, kind, r), {busy, done, detonator_fire, output_trigger, err_code}, exp);
      start = st[r]; fg_opto = op[r]; wire_sensor = wi[r]; detector_ready = rd[r]; reset = rs[r];
      if (r == w) fire_delay = CW'($urandom);
    end
    p_done = od; p_err = code; sn++;
  endtask
  initial begin
    int k;
    repeat (3) @(negedge clk);
    chk("reset", {busy, done, detonator_fire, output_trigger, err_code}, 6'b0);
    reset = 0;
    run_shot(0, 0);
    run_shot(1, $urandom_range(150, 0));
    run_shot(2, $urandom_range(150, 0));
    run_shot(3, $urandom_range(150, 0));
    run_shot(0, $urandom_range(150, 0));
    run_shot(4, $urandom_range(150, 0));
    run_shot(0, $urandom_range(150, 0));
    repeat (20) begin
      k = $urandom_range(8, 0);
      run_shot((k < 5) ? 0 : k - 4, ($urandom_range(4, 0) == 0) ? 0 : $urandom_range(150, 0));
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
